mult32x32_stream_ctrl: RTL and testbench

- Stream front-end and back-end for the iterative 32x32 multiplier.
- Accepts operand pairs over a valid/ready input stream and buffers them in a small FIFO.
- Launches each pair into the multiplier with a start pulse, holding the operands stable for the whole operation.
- Captures the 64-bit product when the multiplier drops busy and presents it on a valid/ready output stream with a job tag.
- Instantiated directly around mult32x32: drives its start/a/b, consumes its busy/product.

---
 rtl/mult_stream_pkg.sv | 26 ++
 rtl/stream_fifo.sv | 66 ++++++
 rtl/mult32x32_stream_ctrl.sv | 188 ++++++++++++++++++
 tb/tb_mult32x32_stream_ctrl.sv | 397 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mult_stream_pkg.sv
// Shared types and constants for the multiplier stream controller.
package mult_stream_pkg;

    // Number of cycles after the start pulse that busy is allowed to take to rise.
    localparam int WAIT_HI_LIMIT = 2;

    // Widest tag a job entry can carry. The top keeps only its TAG_W low bits.
    localparam int JOB_TAG_MAX = 16;

    typedef enum logic [2:0] {
        IDLE,
        LAUNCH,
        WAIT_HI,
        RUN,
        DONE
    } state_t;

    typedef struct packed {
        logic [31:0]            a;
        logic [31:0]            b;
        logic [JOB_TAG_MAX-1:0] tag;
    } job_t;

    localparam int JOB_W = $bits(job_t);

endpackage

// File: rtl/stream_fifo.sv
// Small first-word-fall-through FIFO: the head entry is readable
// combinationally, so a pop and the use of its data happen in one cycle.
module stream_fifo #(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH),
    localparam int LVL_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             empty,
    output logic [LVL_W-1:0] level
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [LVL_W-1:0] r_level;
    logic             w_do_push;
    logic             w_do_pop;
    logic             w_full;
    logic             w_empty;

    assign w_full    = (r_level == LVL_W'(DEPTH));
    assign w_empty   = (r_level == '0);
    // At full, a push is still accepted when the head leaves in the same cycle.
    assign w_do_push = push && (!w_full || pop);
    assign w_do_pop  = pop && !w_empty;

    assign pop_data  = r_mem[r_rd_ptr];
    assign empty     = w_empty;
    assign level     = r_level;

    // Storage write; contents need no reset since level gates every read.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

    // Pointer and occupancy bookkeeping; pointers wrap since DEPTH is a power of two.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_level <= r_level + LVL_W'(1);
                2'b01:   r_level <= r_level - LVL_W'(1);
                default: r_level <= r_level;
            endcase
        end
    end

endmodule

// File: rtl/mult32x32_stream_ctrl.sv
// Valid/ready wrapper around the iterative 32x32 multiplier: buffers operand
// pairs, launches one job at a time, watches busy with a timeout and returns
// tagged 64-bit products in input order.
module mult32x32_stream_ctrl
    import mult_stream_pkg::*;
#(
    parameter  int DEPTH   = 4,
    parameter  int TAG_W   = 4,    // must not exceed JOB_TAG_MAX
    parameter  int TIMEOUT = 64,
    localparam int LVL_W   = $clog2(DEPTH) + 1,
    localparam int CNT_W   = $clog2(TIMEOUT + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_a,
    input  logic [31:0]      in_b,
    input  logic [TAG_W-1:0] in_tag,
    output logic             mul_start,
    output logic [31:0]      mul_a,
    output logic [31:0]      mul_b,
    input  logic             mul_busy,
    input  logic [63:0]      mul_product,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [63:0]      out_product,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_err,
    output logic [LVL_W-1:0] level
);

    state_t           r_state;
    state_t           w_state_next;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_next;
    logic             r_err;
    logic             w_err_next;
    logic [31:0]      r_mul_a;
    logic [31:0]      r_mul_b;
    logic [TAG_W-1:0] r_tag;
    logic             r_out_valid;
    logic [63:0]      r_out_product;
    logic [TAG_W-1:0] r_out_tag;
    logic             r_out_err;

    job_t             w_push_job;
    job_t             w_head;
    logic             w_fifo_push;
    logic             w_fifo_pop;
    logic             w_fifo_empty;
    logic [LVL_W-1:0] w_level;
    logic             w_load_out;
    logic             w_unused_tag;

    // Operand pairs are widened into a job entry before buffering.
    always_comb begin
        w_push_job     = '0;
        w_push_job.a   = in_a;
        w_push_job.b   = in_b;
        w_push_job.tag = JOB_TAG_MAX'(in_tag);
    end

    assign in_ready     = (w_level < LVL_W'(DEPTH));
    assign w_fifo_push  = in_valid && in_ready;
    assign level        = w_level;
    assign w_unused_tag = ^w_head.tag;

    stream_fifo #(
        .WIDTH (JOB_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (w_fifo_push),
        .push_data (w_push_job),
        .pop       (w_fifo_pop),
        .pop_data  (w_head),
        .empty     (w_fifo_empty),
        .level     (w_level)
    );

    // Start is a pure decode of LAUNCH, so it lasts exactly one cycle.
    assign mul_start   = (r_state == LAUNCH);
    assign mul_a       = r_mul_a;
    assign mul_b       = r_mul_b;
    assign out_valid   = r_out_valid;
    assign out_product = r_out_product;
    assign out_tag     = r_out_tag;
    assign out_err     = r_out_err;

    // Job sequencing: pop, launch, wait for busy to rise then fall, deliver.
    // r_cnt counts busy-high cycles, so a job errors once busy exceeds TIMEOUT.
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_err_next   = r_err;
        w_fifo_pop   = 1'b0;
        w_load_out   = 1'b0;
        case (r_state)
            IDLE: begin
                if (!w_fifo_empty) begin
                    w_fifo_pop   = 1'b1;
                    w_state_next = LAUNCH;
                end
            end
            LAUNCH: begin
                w_cnt_next   = '0;
                w_err_next   = 1'b0;
                w_state_next = WAIT_HI;
            end
            WAIT_HI: begin
                if (mul_busy) begin
                    w_cnt_next   = CNT_W'(1);
                    w_state_next = RUN;
                end else if (r_cnt >= CNT_W'(WAIT_HI_LIMIT - 1)) begin
                    w_err_next   = 1'b1;
                    w_state_next = DONE;
                end else begin
                    w_cnt_next = r_cnt + CNT_W'(1);
                end
            end
            RUN: begin
                if (!mul_busy) begin
                    w_state_next = DONE;
                end else if (r_cnt >= CNT_W'(TIMEOUT)) begin
                    w_err_next   = 1'b1;
                    w_state_next = DONE;
                end else begin
                    w_cnt_next = r_cnt + CNT_W'(1);
                end
            end
            DONE: begin
                if (!r_out_valid || out_ready) begin
                    w_load_out   = 1'b1;
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // FSM state, cycle counter and error flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_err   <= w_err_next;
        end
    end

    // Operands and tag are captured only on the pop, keeping them stable for the job.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_mul_a <= '0;
            r_mul_b <= '0;
            r_tag   <= '0;
        end else if (w_fifo_pop) begin
            r_mul_a <= w_head.a;
            r_mul_b <= w_head.b;
            r_tag   <= w_head.tag[TAG_W-1:0];
        end
    end

    // Output register: a reload on the accept edge wins over clearing valid.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_out_valid   <= 1'b0;
            r_out_product <= '0;
            r_out_tag     <= '0;
            r_out_err     <= 1'b0;
        end else if (w_load_out) begin
            r_out_valid   <= 1'b1;
            r_out_product <= r_err ? 64'd0 : mul_product;
            r_out_tag     <= r_tag;
            r_out_err     <= r_err;
        end else if (out_ready) begin
            r_out_valid   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mult32x32_stream_ctrl.sv
// Bench for mult32x32_stream_ctrl: a behavioural multiplier, an in-order
// scoreboard of expected results, and directed plus random job streams.
module tb_mult32x32_stream_ctrl;

    localparam int DEPTH   = 4;
    localparam int TAG_W   = 4;
    localparam int TIMEOUT = 64;
    localparam int LVL_W   = $clog2(DEPTH) + 1;

    logic             clk = 1'b0;
    logic             rst_n = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [31:0]      in_a = '0;
    logic [31:0]      in_b = '0;
    logic [TAG_W-1:0] in_tag = '0;
    logic             mul_start;
    logic [31:0]      mul_a;
    logic [31:0]      mul_b;
    logic             mul_busy = 1'b0;
    logic [63:0]      mul_product = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [63:0]      out_product;
    logic [TAG_W-1:0] out_tag;
    logic             out_err;
    logic [LVL_W-1:0] level;

    int n_vec = 0;
    int n_err = 0;
    int n_out = 0;

    typedef struct { logic [31:0] a; logic [31:0] b; logic [TAG_W-1:0] tag; } in_t;
    typedef struct { logic [63:0] prod; logic [TAG_W-1:0] tag; logic err; } res_t;

    in_t              in_q[$];
    res_t             exp_q[$];
    logic [TAG_W-1:0] got_tags[$];

    bit               long_mode = 1'b0;
    bit               rand_ready = 1'b0;

    mult32x32_stream_ctrl #(
        .DEPTH   (DEPTH),
        .TAG_W   (TAG_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk         (clk),
        .reset       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_a        (in_a),
        .in_b        (in_b),
        .in_tag      (in_tag),
        .mul_start   (mul_start),
        .mul_a       (mul_a),
        .mul_b       (mul_b),
        .mul_busy    (mul_busy),
        .mul_product (mul_product),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_product (out_product),
        .out_tag     (out_tag),
        .out_err     (out_err),
        .level       (level)
    );

    initial forever #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        n_vec++;
        n_err++;
        $display("FAIL %s: bound expired (t=%0t)", name, $time);
    endtask

    // Behavioural multiplier: busy for a chosen number of cycles starting the
    // cycle after start, junk product while busy, final product once idle.
    int          mm_remain = 0;
    int          mm_dur = 1;
    bit          mm_st = 1'b0;
    logic [31:0] mm_a = '0;
    logic [31:0] mm_b = '0;
    logic [63:0] mm_final = '0;
    logic        mm_prev_start = 1'b0;
    in_t         mm_job;
    res_t        mm_res;

    always begin
        @(negedge clk);
        mm_st = 1'b0;
        if (rst_n && mul_start) begin
            mm_st = 1'b1;
            mm_a  = mul_a;
            mm_b  = mul_b;
            mm_dur = long_mode ? TIMEOUT + 5 : int'($urandom_range(1, 12));
            chk("start_single_cycle", 64'(mm_prev_start), 64'd0);
            if (in_q.size() == 0) begin
                fail_now("start_without_job");
            end else begin
                mm_job = in_q.pop_front();
                chk("launch_a", 64'(mm_a), 64'(mm_job.a));
                chk("launch_b", 64'(mm_b), 64'(mm_job.b));
                mm_res.err  = (mm_dur > TIMEOUT);
                mm_res.prod = mm_res.err ? 64'd0 : ({32'd0, mm_job.a} * {32'd0, mm_job.b});
                mm_res.tag  = mm_job.tag;
                exp_q.push_back(mm_res);
            end
        end else if (rst_n && mm_remain > 0) begin
            chk("operand_hold_a", 64'(mul_a), 64'(mm_a));
            chk("operand_hold_b", 64'(mul_b), 64'(mm_b));
        end
        mm_prev_start = rst_n && mul_start;
        @(posedge clk);
        #1;
        if (!rst_n) begin
            mm_remain = 0;
            mul_busy  = 1'b0;
        end else if (mm_st) begin
            mm_remain   = mm_dur;
            mm_final    = {32'd0, mm_a} * {32'd0, mm_b};
            mul_busy    = 1'b1;
            mul_product = {$urandom, $urandom};
        end else if (mm_remain > 0) begin
            mm_remain--;
            if (mm_remain == 0) begin
                mul_busy    = 1'b0;
                mul_product = mm_final;
            end else begin
                mul_product = {$urandom, $urandom};
            end
        end
    end

    // Per-cycle compare: input handshake rule, output stability under
    // backpressure, and each accepted result against the scoreboard.
    logic             pv_hold = 1'b0;
    logic [63:0]      pv_prod = '0;
    logic [TAG_W-1:0] pv_tag = '0;
    logic             pv_err = 1'b0;
    res_t             ck_res;

    always @(negedge clk) begin
        if (!rst_n) begin
            pv_hold = 1'b0;
        end else begin
            chk("in_ready_rule", 64'(in_ready), 64'(level < LVL_W'(DEPTH)));
            if (level > LVL_W'(DEPTH)) chk("level_bound", 64'(level), 64'(DEPTH));
            if (in_valid && in_ready) in_q.push_back('{in_a, in_b, in_tag});
            if (pv_hold) begin
                chk("hold_valid", 64'(out_valid), 64'd1);
                chk("hold_product", out_product, pv_prod);
                chk("hold_tag", 64'(out_tag), 64'(pv_tag));
                chk("hold_err", 64'(out_err), 64'(pv_err));
            end
            if (out_valid && out_ready) begin
                n_out++;
                got_tags.push_back(out_tag);
                if (exp_q.size() == 0) begin
                    fail_now("unexpected_result");
                end else begin
                    ck_res = exp_q.pop_front();
                    chk("result_product", out_product, ck_res.prod);
                    chk("result_tag", 64'(out_tag), 64'(ck_res.tag));
                    chk("result_err", 64'(out_err), 64'(ck_res.err));
                end
            end
            pv_hold = out_valid && !out_ready;
            pv_prod = out_product;
            pv_tag  = out_tag;
            pv_err  = out_err;
        end
    end

    // Random consumer backpressure when enabled.
    always @(posedge clk) begin
        #1;
        if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
    end

    task automatic push_job(input logic [31:0] a, input logic [31:0] b, input logic [TAG_W-1:0] t);
        int n;
        n = 0;
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        in_tag   = t;
        @(negedge clk);
        while (!in_ready && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) fail_now("push_wait");
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_result(output logic [63:0] p, output logic [TAG_W-1:0] t, output logic e);
        int n;
        n = 0;
        @(negedge clk);
        while (!(out_valid && out_ready) && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (!(out_valid && out_ready)) fail_now("result_wait");
        p = out_product;
        t = out_tag;
        e = out_err;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        @(negedge clk);
        while ((exp_q.size() != 0 || in_q.size() != 0 || out_valid) && n < 4000) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0 || in_q.size() != 0 || out_valid) fail_now(name);
    endtask

    task automatic check_reset_outputs(input string tag_name);
        chk({tag_name, "_in_ready"}, 64'(in_ready), 64'd1);
        chk({tag_name, "_mul_start"}, 64'(mul_start), 64'd0);
        chk({tag_name, "_mul_a"}, 64'(mul_a), 64'd0);
        chk({tag_name, "_mul_b"}, 64'(mul_b), 64'd0);
        chk({tag_name, "_out_valid"}, 64'(out_valid), 64'd0);
        chk({tag_name, "_out_product"}, out_product, 64'd0);
        chk({tag_name, "_out_tag"}, 64'(out_tag), 64'd0);
        chk({tag_name, "_out_err"}, 64'(out_err), 64'd0);
        chk({tag_name, "_level"}, 64'(level), 64'd0);
    endtask

    logic [63:0]      r_p;
    logic [TAG_W-1:0] r_t;
    logic             r_e;

    initial begin
        int n;
        int base;
        logic [31:0] ra;
        logic [31:0] rb;

        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Single small job.
        out_ready = 1'b1;
        push_job(32'h0000_0003, 32'h0000_0005, 4'd1);
        wait_result(r_p, r_t, r_e);
        chk("single_product", r_p, 64'h0F);
        chk("single_tag", 64'(r_t), 64'd1);
        chk("single_err", 64'(r_e), 64'd0);

        // Largest operands.
        push_job(32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd2);
        wait_result(r_p, r_t, r_e);
        chk("max_product", r_p, 64'hFFFF_FFFE_0000_0001);
        chk("max_tag", 64'(r_t), 64'd2);

        // Fill under backpressure: two jobs park in the output path, DEPTH in the FIFO.
        wait_drain("pre_fill_drain");
        out_ready = 1'b0;
        got_tags.delete();
        for (int i = 0; i < DEPTH + 2; i++) begin
            push_job(32'(i * 3 + 1), 32'(i + 7), TAG_W'(i));
        end
        repeat (40) @(negedge clk);
        chk("full_level", 64'(level), 64'(DEPTH));
        chk("full_in_ready", 64'(in_ready), 64'd0);
        // Offer one more job while full; it must wait, not overwrite.
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        in_a     = 32'h0001_0000;
        in_b     = 32'h0000_0100;
        in_tag   = TAG_W'(DEPTH + 2);
        repeat (5) @(negedge clk);
        chk("full_stall_level", 64'(level), 64'(DEPTH));
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) fail_now("full_release");
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        wait_drain("fill_drain");
        chk("fill_count", 64'(got_tags.size()), 64'(DEPTH + 3));
        for (int k = 0; k < got_tags.size(); k++) begin
            chk("fill_tag_order", 64'(got_tags[k]), 64'(k));
        end

        // Timeout: busy stays high past the limit.
        long_mode = 1'b1;
        push_job(32'h0000_1234, 32'h0000_0010, 4'd5);
        wait_result(r_p, r_t, r_e);
        chk("timeout_err", 64'(r_e), 64'd1);
        chk("timeout_product", r_p, 64'd0);
        chk("timeout_tag", 64'(r_t), 64'd5);
        long_mode = 1'b0;
        n = 0;
        while (mul_busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (mul_busy) fail_now("timeout_busy_release");
        push_job(32'd7, 32'd6, 4'd6);
        wait_result(r_p, r_t, r_e);
        chk("after_timeout_product", r_p, 64'd42);
        chk("after_timeout_err", 64'(r_e), 64'd0);

        // Random stream with random consumer backpressure.
        wait_drain("pre_random_drain");
        base = n_out;
        rand_ready = 1'b1;
        for (int j = 0; j < 40; j++) begin
            repeat ($urandom_range(0, 3)) @(posedge clk);
            case ($urandom_range(0, 5))
                0:       ra = 32'd0;
                1:       ra = 32'hFFFF_FFFF;
                default: ra = $urandom;
            endcase
            rb = ($urandom_range(0, 5) == 0) ? 32'hFFFF_FFFF : $urandom;
            push_job(ra, rb, TAG_W'($urandom_range(0, 15)));
        end
        wait_drain("random_drain");
        chk("random_count", 64'(n_out - base), 64'd40);
        rand_ready = 1'b0;
        @(posedge clk);
        #1;

        // Reset mid-job with a finished result still unconsumed.
        out_ready = 1'b0;
        push_job(32'd2, 32'd3, 4'd7);
        push_job(32'h0000_AAAA, 32'h0000_5555, 4'd8);
        n = 0;
        base = 0;
        while (base < 3 && n < 200) begin
            @(negedge clk);
            if (mul_busy) base++;
            n++;
        end
        if (base < 3) fail_now("reset_wait_run");
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("async_reset");
        in_q.delete();
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        out_ready = 1'b1;
        push_job(32'd7, 32'd9, 4'd3);
        wait_result(r_p, r_t, r_e);
        chk("post_reset_product", r_p, 64'd63);
        chk("post_reset_tag", 64'(r_t), 64'd3);

        wait_drain("final_drain");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
        $fatal(1);
    end

endmodule
